// File: rtl/adc_sample_sched.sv
// adc_sample_sched: APB-programmed ADC sample scheduler.
// Emits timed sample strobes to a downstream FIFO, in one-shot or continuous bursts.
module adc_sample_sched #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   input  logic [15:0]       i_sample,
   input  logic              fifo_full,
   output logic [31:0]       o_data,
   output logic              o_data_v,
   output logic              irq
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_PERIOD = 8'h04;
   localparam logic [7:0] A_COUNT  = 8'h08;
   localparam logic [7:0] A_STATUS = 8'h0C;
   localparam logic [7:0] A_START  = 8'h10;

   state_t      state_q, state_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] period_q, period_d;
   logic [15:0] count_q, count_d;
   logic [15:0] timer_q, timer_d;
   logic [15:0] issued_q, issued_d, issued_inc;
   logic [15:0] period_eff, count_eff;
   logic        done_q, done_d, ovf_q, ovf_d;
   logic        done_set, ovf_set, busy;
   logic        wr_acc, wr_ctrl, wr_period, wr_count, wr_status, wr_start;
   logic [7:0]  addr;
   logic        unused_bits;

   assign addr        = paddr[7:0];
   assign unused_bits = ^{paddr[ADDR_W-1:8], pwdata[31:16]};

   assign wr_acc    = psel & penable & pwrite;
   assign wr_ctrl   = wr_acc && (addr == A_CTRL);
   assign wr_period = wr_acc && (addr == A_PERIOD);
   assign wr_count  = wr_acc && (addr == A_COUNT);
   assign wr_status = wr_acc && (addr == A_STATUS);
   assign wr_start  = wr_acc && (addr == A_START);

   assign ctrl_d   = wr_ctrl   ? pwdata[2:0]  : ctrl_q;
   assign period_d = wr_period ? pwdata[15:0] : period_q;
   assign count_d  = wr_count  ? pwdata[15:0] : count_q;

   // Zero-valued PERIOD/COUNT behave as 1 so a burst always makes progress.
   assign period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
   assign count_eff  = (count_q  == 16'd0) ? 16'd1 : count_q;
   // The index only rolls over in continuous mode; one-shot runs saturate.
   assign issued_inc = (ctrl_q[1] || (issued_q != 16'hFFFF)) ? issued_q + 16'd1 : issued_q;

   assign busy = (state_q == S_WAIT) || (state_q == S_SAMPLE);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      issued_d = issued_q;
      done_set = 1'b0;
      ovf_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_start && ctrl_q[0]) begin
               state_d  = S_WAIT;
               timer_d  = period_eff;
               issued_d = 16'd0;
            end
         end
         S_WAIT: begin
            // Looking at the incoming RUN value lets a clearing write abort on the next edge.
            if (!ctrl_d[0])             state_d = S_IDLE;
            else if (timer_q <= 16'd1)  state_d = S_SAMPLE;
            else                        timer_d = timer_q - 16'd1;
         end
         S_SAMPLE: begin
            ovf_set  = fifo_full;
            issued_d = issued_inc;
            timer_d  = period_eff;
            if (!ctrl_d[0]) begin
               state_d = S_IDLE;
            end else if (issued_inc == count_eff) begin
               if (ctrl_q[1]) begin
                  issued_d = 16'd0;
                  state_d  = S_WAIT;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            done_set = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A hardware set in the same cycle as a W1C keeps the flag set.
   assign done_d = done_set | (done_q & ~(wr_status & pwdata[1]));
   assign ovf_d  = ovf_set  | (ovf_q  & ~(wr_status & pwdata[2]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ctrl_q   <= 3'd0;
         period_q <= 16'd0;
         count_q  <= 16'd0;
         timer_q  <= 16'd0;
         issued_q <= 16'd0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         issued_q <= issued_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      prdata = 32'h0;
      if (psel && !pwrite) begin
         case (addr)
            A_CTRL:   prdata = {29'd0, ctrl_q};
            A_PERIOD: prdata = {16'd0, period_q};
            A_COUNT:  prdata = {16'd0, count_q};
            A_STATUS: prdata = {issued_q, 13'd0, ovf_q, done_q, busy};
            default:  prdata = 32'h0;
         endcase
      end
   end

   assign o_data_v = (state_q == S_SAMPLE) && !fifo_full;
   assign o_data   = (state_q == S_SAMPLE) ? {issued_q, i_sample} : 32'h0;
   assign irq      = done_q & ctrl_q[2];

endmodule

// File: tb/tb_adc_sample_sched.sv
// Directed bench for adc_sample_sched: expected strobes are queued at stimulus time
// and a negedge monitor pops and compares each o_data_v beat.
module tb_adc_sample_sched;
   logic        clk;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [15:0] i_sample;
   logic        fifo_full;
   logic [31:0] o_data;
   logic        o_data_v;
   logic        irq;

   logic [31:0] cyc;
   logic [31:0] full_cyc;
   logic [63:0] exp_q[$];
   int          pass_cnt;
   int          total_cnt;

   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_PERIOD = 8'h04;
   localparam logic [7:0] A_COUNT  = 8'h08;
   localparam logic [7:0] A_STATUS = 8'h0C;
   localparam logic [7:0] A_START  = 8'h10;

   adc_sample_sched #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .i_sample(i_sample),
      .fifo_full(fifo_full), .o_data(o_data), .o_data_v(o_data_v), .irq(irq)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   assign i_sample  = {cyc[7:0], 8'h5A};
   assign fifo_full = (cyc == full_cyc);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic push_strobe(input logic [31:0] c, input logic [15:0] idx);
      exp_q.push_back({c, idx, c[7:0], 8'h5A});
   endtask

   // driver tasks
   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic [31:0] t);
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = {24'h0, a}; pwdata = d;
      t = cyc;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] t;
      apb_write(a, d, t);
   endtask

   task automatic read_now(input logic [7:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {24'h0, a};
      #1 d = prdata;
      psel = 1'b0; penable = 1'b0; paddr = 32'h0;
   endtask

   task automatic rd_chk_now(input string name, input logic [7:0] a, input logic [31:0] e);
      logic [31:0] d;
      read_now(a, d);
      check(name, {32'h0, d}, {32'h0, e});
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] e);
      @(negedge clk);
      rd_chk_now(name, a, e);
   endtask

   task automatic wait_until(input logic [31:0] c);
      while (cyc < c) @(negedge clk);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (o_data_v) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_strobe: got o_data %h at cycle %0d, required no strobe", o_data, cyc);
         end else begin
            check("strobe{cycle,data}", {cyc, o_data}, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] t;
      logic [31:0] w;
      pass_cnt = 0; total_cnt = 0;
      full_cyc = 32'hFFFF_FFFF;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      check("reset_o_data_v", {63'h0, o_data_v}, 64'h0);
      check("reset_irq", {63'h0, irq}, 64'h0);
      check("reset_prdata_unsel", {32'h0, prdata}, 64'h0);
      rd_chk("reset_ctrl", A_CTRL, 32'h0);
      rd_chk("reset_period", A_PERIOD, 32'h0);
      rd_chk("reset_count", A_COUNT, 32'h0);
      rd_chk("reset_status", A_STATUS, 32'h0);

      // one-shot burst: PERIOD=3, COUNT=4
      wr(A_CTRL, 32'hFFFF_FFF9);
      rd_chk("ctrl_unused_bits", A_CTRL, 32'h1);
      wr(A_PERIOD, 32'hABCD_0003);
      rd_chk("period_unused_bits", A_PERIOD, 32'h3);
      wr(A_COUNT, 32'h4);
      apb_write(A_START, 32'h0, t);
      for (int k = 1; k <= 4; k++) push_strobe(t + 4 * k, 16'(k - 1));
      wait_until(t + 2);
      rd_chk_now("burst_busy", A_STATUS, 32'h0000_0001);
      wait_until(t + 17);
      rd_chk_now("burst_pre_done", A_STATUS, 32'h0004_0000);
      wait_until(t + 18);
      rd_chk_now("burst_done", A_STATUS, 32'h0004_0002);
      check("burst_no_irq", {63'h0, irq}, 64'h0);

      // irq follows DONE when enabled, W1C clears it
      wr(A_STATUS, 32'h2);
      wr(A_CTRL, 32'h5);
      check("irq_after_clear", {63'h0, irq}, 64'h0);
      apb_write(A_START, 32'h0, t);
      for (int k = 1; k <= 4; k++) push_strobe(t + 4 * k, 16'(k - 1));
      wait_until(t + 17);
      check("irq_before_done", {63'h0, irq}, 64'h0);
      wait_until(t + 18);
      check("irq_with_done", {63'h0, irq}, 64'h1);
      apb_write(A_STATUS, 32'h2, w);
      check("irq_w1c", {63'h0, irq}, 64'h0);

      // FIFO full on the second of three samples
      wr(A_CTRL, 32'h1);
      wr(A_COUNT, 32'h3);
      apb_write(A_START, 32'h0, t);
      full_cyc = t + 8;
      push_strobe(t + 4, 16'd0);
      push_strobe(t + 12, 16'd2);
      wait_until(t + 9);
      rd_chk_now("ovf_mid_burst", A_STATUS, 32'h0002_0005);
      wait_until(t + 14);
      rd_chk_now("ovf_done", A_STATUS, 32'h0003_0006);
      full_cyc = 32'hFFFF_FFFF;
      wr(A_STATUS, 32'h6);
      rd_chk("ovf_done_w1c", A_STATUS, 32'h0003_0000);

      // set beats W1C in the same cycle (COUNT=1)
      wr(A_COUNT, 32'h1);
      apb_write(A_START, 32'h0, t);
      push_strobe(t + 4, 16'd0);
      wait_until(t + 4);
      apb_write(A_STATUS, 32'h2, w);
      check("w1c_cycle", {32'h0, w}, {32'h0, t + 32'd5});
      rd_chk_now("set_wins", A_STATUS, 32'h0001_0002);
      wr(A_STATUS, 32'h2);
      rd_chk("set_wins_cleared", A_STATUS, 32'h0001_0000);

      // continuous mode, PERIOD=0, COUNT=2, then abort by clearing RUN
      wr(A_PERIOD, 32'h0);
      wr(A_COUNT, 32'h2);
      wr(A_CTRL, 32'h3);
      apb_write(A_START, 32'h0, t);
      for (int k = 1; k <= 5; k++) push_strobe(t + 2 * k, 16'((k - 1) % 2));
      wait_until(t + 10);
      wr(A_CTRL, 32'h2);
      wait_until(t + 13);
      rd_chk_now("cont_abort_status", A_STATUS, 32'h0001_0000);
      rd_chk_now("cont_abort_ctrl", A_CTRL, 32'h2);
      wait_until(t + 24);

      // START while busy is ignored
      wr(A_PERIOD, 32'h3);
      wr(A_COUNT, 32'h2);
      wr(A_CTRL, 32'h1);
      apb_write(A_START, 32'h0, t);
      push_strobe(t + 4, 16'd0);
      push_strobe(t + 8, 16'd1);
      wait_until(t + 5);
      wr(A_START, 32'h0);
      rd_chk_now("start_busy_ignored", A_STATUS, 32'h0001_0001);
      wait_until(t + 10);
      rd_chk_now("start_busy_done", A_STATUS, 32'h0002_0002);

      // START with RUN=0 is ignored
      wr(A_CTRL, 32'h0);
      wr(A_START, 32'h0);
      rd_chk("start_norun_ignored", A_STATUS, 32'h0002_0002);

      // decode corners
      wr(A_CTRL, 32'h5);
      check("irq_level", {63'h0, irq}, 64'h1);
      rd_chk("undef_read", 8'h14, 32'h0);
      wr(8'h14, 32'hFFFF_FFFF);
      rd_chk("undef_write_ignored", A_CTRL, 32'h5);
      rd_chk("start_reads_zero", A_START, 32'h0);
      @(negedge clk);
      psel = 1'b0; pwrite = 1'b0; paddr = {24'h0, A_CTRL};
      #1 check("read_psel0", {32'h0, prdata}, 64'h0);
      paddr = 32'h0;
      wr(A_STATUS, 32'h1);
      rd_chk("busy_not_writable", A_STATUS, 32'h0002_0002);

      // asynchronous reset mid-WAIT
      apb_write(A_START, 32'h0, t);
      wait_until(t + 2);
      rd_chk_now("pre_reset_status", A_STATUS, 32'h0000_0003);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_irq", {63'h0, irq}, 64'h0);
      check("async_rst_o_data_v", {63'h0, o_data_v}, 64'h0);
      check("async_rst_o_data", {32'h0, o_data}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_chk("post_reset_status", A_STATUS, 32'h0);
      rd_chk("post_reset_ctrl", A_CTRL, 32'h0);
      wait_until(t + 20);

      check("scoreboard_drained", {32'h0, 32'(exp_q.size())}, 64'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/adc_sample_sched.md
ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of paddr; only paddr[7:0] is decoded.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- psel  in  1  APB select, pre-decoded upstream
- penable  in  1  APB access phase
- pwrite  in  1  APB write
- paddr  in  ADDR_W  APB address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data; zero when not read-selected (ORed upstream)
- i_sample  in  16  raw ADC value, sampled when a sample is due
- fifo_full  in  1  downstream FIFO cannot accept data
- o_data  out  32  {sample_index[15:0], i_sample[15:0]}
- o_data_v  out  1  one-cycle data strobe to FIFO
- irq  out  1  level interrupt
REQ-003 SHALL use only clk, with rst_n asynchronous active-low.

Function
REQ-004 SHALL decode registers on paddr[7:0]: 0x00 CTRL RW {[2] IRQ_EN, [1] CONT, [0] RUN}; 0x04 PERIOD RW [15:0]; 0x08 COUNT RW [15:0]; 0x0C STATUS {[31:16] issued RO, [2] OVF W1C, [1] DONE W1C, [0] BUSY RO}; 0x10 START WO (any write).
REQ-005 SHALL commit writes in the cycle psel&penable&pwrite=1; unused bits read 0, undefined addresses read 0 and ignore writes.
REQ-006 SHALL drive prdata combinationally when psel&!pwrite, else 32'h0; START reads 0.
REQ-007 SHALL implement FSM IDLE, WAIT, SAMPLE, DONE; BUSY=1 in WAIT and SAMPLE.
REQ-008 IDLE->WAIT on START write with RUN=1; timer loaded with PERIOD (0 treated as 1), issued cleared to 0.
REQ-009 START while BUSY or RUN=0 SHALL be ignored.
REQ-010 WAIT: timer decrements each cycle; timer==1 -> SAMPLE next cycle; WAIT lasts PERIOD cycles, spacing between strobes is PERIOD+1 clocks.
REQ-011 SAMPLE (one cycle): if fifo_full=0, o_data_v=1 with o_data={issued, i_sample}; if fifo_full=1, o_data_v=0 and OVF set; issued increments either way (dropped samples consume a slot).
REQ-012 After SAMPLE: if issued (post-increment) == COUNT (0 treated as 1) and CONT=0 -> DONE; if CONT=1 -> WAIT with issued cleared; else WAIT with timer reloaded.
REQ-013 DONE (one cycle): set DONE sticky, then IDLE.
REQ-014 RUN cleared while BUSY SHALL force IDLE next cycle; no further o_data_v; DONE not set; issued holds.
REQ-015 issued is 16 bits and wraps 0xFFFF->0 in CONT mode only.
REQ-016 Hardware set and W1C of DONE/OVF in the same cycle: set wins.
REQ-017 PERIOD/COUNT writes while BUSY take effect at next timer reload / next compare.
REQ-018 irq = DONE & IRQ_EN, combinational from registers.
REQ-019 o_data_v SHALL be 0 outside SAMPLE.

Reset
REQ-020 rst_n=0 SHALL immediately clear: FSM=IDLE, CTRL=0, PERIOD=0, COUNT=0, timer=0, issued=0, DONE=0, OVF=0, o_data_v=0, o_data=0, irq=0, prdata=0 (when unselected).
REQ-021 Reset mid-burst SHALL abort without emitting o_data_v; operation resumes only after a new START.

Verification
REQ-022 CTRL=1, PERIOD=3, COUNT=4, START at cycle T -> o_data_v at T+4, T+8, T+12, T+16; o_data[31:16]=0,1,2,3; DONE=1 at T+18; STATUS reads 0x0004_0002.
REQ-023 IRQ_EN=1, same burst -> irq rises with DONE; W1C 0x2 to STATUS -> irq=0 next cycle.
REQ-024 fifo_full=1 during second sample of COUNT=3 -> two strobes (index 0 and 2), OVF=1, DONE=1, issued=3.
REQ-025 CONT=1, PERIOD=0, COUNT=2 -> strobes every 2 cycles, indices 0,1,0,1...; clear RUN -> IDLE next cycle, no further strobes, DONE=0.
REQ-026 START while BUSY and START with RUN=0 -> no state change; rst_n asserted mid-WAIT -> all outputs 0 asynchronously, STATUS=0 after release.
REQ-027 Read of 0x14 and read with psel=0 -> prdata=0; write to 0x0C bit0 -> BUSY unaffected.
